// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter advanced by rising edges of an asynchronous 1 Hz sec_clk.
// Provides a validated load path, a run enable and nested rollover strobes.
module time_of_day_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_clk,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_err
);

  typedef enum logic {HOLD, RUN} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [7:0]             hh_q, hh_d;
  logic [7:0]             mm_q, mm_d;
  logic [7:0]             ss_q, ss_d;
  logic                   sec_tick_q, sec_tick_d;
  logic                   min_tick_q, min_tick_d;
  logic                   hour_tick_q, hour_tick_d;
  logic                   day_tick_q, day_tick_d;
  logic                   load_err_q, load_err_d;

  logic rise;
  logic count_en;
  logic tick;
  logic ld_ok;
  logic ss_lo_wrap, ss_wrap;
  logic mm_lo_wrap, mm_wrap;
  logic hh_lo_wrap, hh_wrap;

  // Synchronizer and prev start high so a sec_clk already high at reset release is not a tick.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sec_clk};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (run) begin
      state_d = RUN;
    end else begin
      state_d = HOLD;
    end
  end

  // The state being entered this edge gates the rise, so run acts in the same cycle it is sampled.
  always_comb begin
    count_en = 1'b0;
    if (state_d == RUN) begin
      count_en = 1'b1;
    end
  end

  assign tick = rise & count_en;

  assign ld_ok = (ld_hh[7:4] <= 4'd2) && (ld_hh[3:0] <= 4'd9) &&
                 ((ld_hh[7:4] != 4'd2) || (ld_hh[3:0] <= 4'd3)) &&
                 (ld_mm[7:4] <= 4'd5) && (ld_mm[3:0] <= 4'd9) &&
                 (ld_ss[7:4] <= 4'd5) && (ld_ss[3:0] <= 4'd9);

  assign ss_lo_wrap = (ss_q[3:0] == 4'd9);
  assign ss_wrap    = (ss_q == 8'h59);
  assign mm_lo_wrap = (mm_q[3:0] == 4'd9);
  assign mm_wrap    = (mm_q == 8'h59);
  assign hh_lo_wrap = (hh_q[3:0] == 4'd9);
  assign hh_wrap    = (hh_q == 8'h23);

  // A valid load beats a simultaneous tick; a rejected load lets the tick through.
  always_comb begin
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    sec_tick_d  = 1'b0;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    load_err_d  = 1'b0;
    if (load && ld_ok) begin
      hh_d = ld_hh;
      mm_d = ld_mm;
      ss_d = ld_ss;
    end else begin
      load_err_d = load;
      if (tick) begin
        sec_tick_d = 1'b1;
        if (ss_wrap) begin
          ss_d = 8'h00;
        end else if (ss_lo_wrap) begin
          ss_d = {ss_q[7:4] + 4'd1, 4'h0};
        end else begin
          ss_d = {ss_q[7:4], ss_q[3:0] + 4'd1};
        end
        if (ss_wrap) begin
          min_tick_d = 1'b1;
          if (mm_wrap) begin
            mm_d = 8'h00;
          end else if (mm_lo_wrap) begin
            mm_d = {mm_q[7:4] + 4'd1, 4'h0};
          end else begin
            mm_d = {mm_q[7:4], mm_q[3:0] + 4'd1};
          end
          if (mm_wrap) begin
            hour_tick_d = 1'b1;
            if (hh_wrap) begin
              hh_d       = 8'h00;
              day_tick_d = 1'b1;
            end else if (hh_lo_wrap) begin
              hh_d = {hh_q[7:4] + 4'd1, 4'h0};
            end else begin
              hh_d = {hh_q[7:4], hh_q[3:0] + 4'd1};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_q        <= 8'h00;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      sec_tick_q  <= sec_tick_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
  assign day_tick  = day_tick_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter: sync latency, BCD rollovers,
// load validation, run gating, load/tick collisions and asynchronous reset.
module tb_time_of_day_counter;

  logic       clk;
  logic       rst_n;
  logic       sec_clk;
  logic       run;
  logic       load;
  logic [7:0] ld_hh;
  logic [7:0] ld_mm;
  logic [7:0] ld_ss;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       sec_tick;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       load_err;

  int num_checks = 0;
  int num_fail   = 0;

  logic [23:0] mid_time;
  logic [23:0] cap_time;
  logic [3:0]  cap_strb;
  logic [3:0]  after_strb;
  logic        cap_err;
  logic        after_err;
  int          stray;

  time_of_day_counter #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sec_clk   (sec_clk),
    .run       (run),
    .load      (load),
    .ld_hh     (ld_hh),
    .ld_mm     (ld_mm),
    .ld_ss     (ld_ss),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .sec_tick  (sec_tick),
    .min_tick  (min_tick),
    .hour_tick (hour_tick),
    .day_tick  (day_tick),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] curTime();
    return {hh, mm, ss};
  endfunction

  function automatic logic [3:0] curStrb();
    return {sec_tick, min_tick, hour_tick, day_tick};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One-cycle load request; captures load_err at the loading edge and one edge later.
  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    load  = 1'b1;
    ld_hh = h;
    ld_mm = m;
    ld_ss = s;
    @(posedge clk);
    #1;
    cap_err = load_err;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    after_err = load_err;
  endtask

  // One sec_clk pulse; edge k is the first posedge that samples it high.
  task automatic doRise(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic with_load);
    @(negedge clk);
    sec_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    mid_time = curTime();
    if (with_load) begin
      @(negedge clk);
      load  = 1'b1;
      ld_hh = h;
      ld_mm = m;
      ld_ss = s;
    end
    @(posedge clk);
    #1;
    cap_time = curTime();
    cap_strb = curStrb();
    cap_err  = load_err;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    after_strb = curStrb();
    repeat (6) @(negedge clk);
    sec_clk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    sec_clk = 1'b1;
    run     = 1'b0;
    load    = 1'b0;
    ld_hh   = 8'h00;
    ld_mm   = 8'h00;
    ld_ss   = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_time", {8'h0, curTime()}, 32'h000000);
    checkOutput("reset_strb", {28'h0, curStrb()}, 32'h0);
    checkOutput("reset_err", {31'h0, load_err}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    stray = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (sec_tick) stray++;
    end
    checkOutput("high_at_reset_no_tick", stray, 0);
    checkOutput("high_at_reset_time", {8'h0, curTime()}, 32'h000000);
    @(negedge clk);
    sec_clk = 1'b0;
    repeat (8) @(negedge clk);

    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("first_rise_k1", {8'h0, mid_time}, 32'h000000);
    checkOutput("first_rise_k2", {8'h0, cap_time}, 32'h000001);
    checkOutput("first_rise_strb", {28'h0, cap_strb}, 32'h8);
    checkOutput("first_rise_strb_1cyc", {28'h0, after_strb}, 32'h0);

    applyStimulus(8'h23, 8'h59, 8'h58);
    checkOutput("load_235958_err", {31'h0, cap_err}, 32'h0);
    checkOutput("load_235958_time", {8'h0, curTime()}, 32'h235958);
    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("to_235959_time", {8'h0, cap_time}, 32'h235959);
    checkOutput("to_235959_strb", {28'h0, cap_strb}, 32'h8);
    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("day_wrap_time", {8'h0, cap_time}, 32'h000000);
    checkOutput("day_wrap_strb", {28'h0, cap_strb}, 32'hF);
    checkOutput("day_wrap_strb_1cyc", {28'h0, after_strb}, 32'h0);

    applyStimulus(8'h00, 8'h09, 8'h59);
    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("min_wrap_time", {8'h0, cap_time}, 32'h001000);
    checkOutput("min_wrap_strb", {28'h0, cap_strb}, 32'hC);

    applyStimulus(8'h09, 8'h59, 8'h59);
    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("hour_wrap_time", {8'h0, cap_time}, 32'h100000);
    checkOutput("hour_wrap_strb", {28'h0, cap_strb}, 32'hE);

    applyStimulus(8'h00, 8'h00, 8'h09);
    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("sec_digit_time", {8'h0, cap_time}, 32'h000010);
    checkOutput("sec_digit_strb", {28'h0, cap_strb}, 32'h8);

    applyStimulus(8'h24, 8'h00, 8'h00);
    checkOutput("bad_24_err", {31'h0, cap_err}, 32'h1);
    checkOutput("bad_24_err_1cyc", {31'h0, after_err}, 32'h0);
    checkOutput("bad_24_time", {8'h0, curTime()}, 32'h000010);
    applyStimulus(8'h12, 8'h5A, 8'h00);
    checkOutput("bad_5A_err", {31'h0, cap_err}, 32'h1);
    checkOutput("bad_5A_time", {8'h0, curTime()}, 32'h000010);
    applyStimulus(8'h12, 8'h60, 8'h00);
    checkOutput("bad_60_err", {31'h0, cap_err}, 32'h1);
    checkOutput("bad_60_time", {8'h0, curTime()}, 32'h000010);
    applyStimulus(8'h12, 8'h34, 8'h56);
    checkOutput("good_123456_err", {31'h0, cap_err}, 32'h0);
    checkOutput("good_123456_time", {8'h0, curTime()}, 32'h123456);

    run   = 1'b0;
    stray = 0;
    repeat (5) begin
      doRise(8'h00, 8'h00, 8'h00, 1'b0);
      if (cap_strb != 4'h0 || after_strb != 4'h0) stray++;
    end
    checkOutput("hold_no_strb", stray, 0);
    checkOutput("hold_time", {8'h0, curTime()}, 32'h123456);
    run = 1'b1;
    doRise(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("resume_time", {8'h0, cap_time}, 32'h123457);
    checkOutput("resume_strb", {28'h0, cap_strb}, 32'h8);

    doRise(8'h08, 8'h00, 8'h00, 1'b1);
    checkOutput("collide_load_time", {8'h0, cap_time}, 32'h080000);
    checkOutput("collide_load_strb", {28'h0, cap_strb}, 32'h0);
    checkOutput("collide_load_err", {31'h0, cap_err}, 32'h0);
    checkOutput("collide_load_after", {28'h0, after_strb}, 32'h0);

    doRise(8'h99, 8'h00, 8'h00, 1'b1);
    checkOutput("collide_bad_err", {31'h0, cap_err}, 32'h1);
    checkOutput("collide_bad_time", {8'h0, cap_time}, 32'h080001);
    checkOutput("collide_bad_strb", {28'h0, cap_strb}, 32'h8);

    applyStimulus(8'h10, 8'h20, 8'h30);
    @(negedge clk);
    sec_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_time", {8'h0, curTime()}, 32'h102031);
    checkOutput("pre_reset_strb", {28'h0, curStrb()}, 32'h8);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_time", {8'h0, curTime()}, 32'h000000);
    checkOutput("async_reset_strb", {28'h0, curStrb()}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Timekeeping consumer of the 1 Hz `sec_clk` square wave from the seconds clock generator. It synchronizes `sec_clk` into the system clock domain and detects its rising edges. Each rising edge advances a 24-hour BCD time-of-day counter (HH:MM:SS). The block also provides a load path for setting the time, a run enable, and single-cycle rollover strobes for the display and alarm logic downstream.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the `sec_clk` synchronizer; legal range 2..4.
- `clk`  input  1  system clock; all state on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sec_clk`  input  1  1 Hz square wave, asynchronous to `clk`; period ≥ 4·(SYNC_STAGES+1) `clk` cycles.
- `run`  input  1  1 = count seconds; 0 = hold, and edges are consumed but ignored.
- `load`  input  1  one-cycle request to set the time from `ld_hh`/`ld_mm`/`ld_ss`.
- `ld_hh`  input  8  BCD hours, 00..23.
- `ld_mm`  input  8  BCD minutes, 00..59.
- `ld_ss`  input  8  BCD seconds, 00..59.
- `hh`  output  8  BCD hours.
- `mm`  output  8  BCD minutes.
- `ss`  output  8  BCD seconds.
- `sec_tick`  output  1  one-cycle strobe on every counted second.
- `min_tick`  output  1  one-cycle strobe when `ss` wraps 59→00.
- `hour_tick`  output  1  one-cycle strobe when `mm` wraps 59→00.
- `day_tick`  output  1  one-cycle strobe on the wrap 23:59:59→00:00:00.
- `load_err`  output  1  one-cycle strobe when a load is rejected.

## Operation
- Synchronizer: chain of SYNC_STAGES flops followed by a `prev` flop.
  - `rise` = last sync stage & ~`prev`.
  - All synchronizer flops and `prev` reset to 1. A `sec_clk` that is high at reset release therefore produces no tick. The first counted edge is a genuine 0→1 transition after reset.
- States:
  - HOLD: entered from reset and whenever `run`=0. `rise` is ignored, with no catch-up later.
  - RUN: entered whenever `run`=1. `rise` advances the time.
  - No other states.
- Increment: BCD per digit.
  - `ss` low digit 9→0 carries into the high digit. `ss` 59→00 carries into `mm`.
  - `mm` 59→00 carries into `hh`.
  - `hh` 23→00 sets `day_tick`. Hours wrap at 23, not 99 or 29.
- Strobes:
  - `sec_tick` is asserted on every counted `rise`.
  - `min_tick`, `hour_tick` and `day_tick` are asserted in the same cycle that the corresponding field wraps.
  - They nest: `day_tick` ⇒ `hour_tick` ⇒ `min_tick` ⇒ `sec_tick`.
- Load:
  - Accepted only if all six BCD digits are valid and the values are in range (hh ≤ 23, mm ≤ 59, ss ≤ 59).
  - An accepted load overwrites all three fields at the next edge, in either state.
  - An invalid load (any nibble > 9 or out of range) leaves the fields unchanged and pulses `load_err`.
- Simultaneous `load` and counted `rise`:
  - A valid load wins and the tick is discarded, so no strobes fire.
  - An invalid load pulses `load_err` and the tick is still counted.
- Reset (asynchronous, any time including mid-count):
  - `hh`/`mm`/`ss` = 00:00:00.
  - All strobes and `load_err` = 0.
  - State = HOLD.
  - Synchronizer flops and `prev` = 1.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Tick latency: if `sec_clk` is first sampled high at `clk` edge k, the fields and strobes update at edge k+SYNC_STAGES (edge k+2 for the default). Strobes stay high for exactly one cycle.
- Load latency: `load` sampled at edge k updates the fields, or pulses `load_err`, at edge k.
- `run` sampled at edge k governs any `rise` evaluated at edge k.
- One `sec_clk` rising edge yields exactly one `sec_tick`, given the minimum period above. Glitch-free `sec_clk` is required.
- State after the last flop is stable within one `clk` period after `rst_n` deasserts; the first count needs a 0→1 on `sec_clk`.

## Test plan
- Reset with `sec_clk`=1, release, `run`=1, hold `sec_clk` high for 10 cycles → no `sec_tick`, time 00:00:00. On the next 0→1, `ss`=01 exactly 2 cycles after it is first sampled.
- Load 23:59:58, `run`=1, apply 2 `sec_clk` rises → first gives 23:59:59 with `sec_tick` only. Second gives 00:00:00 with `sec_tick`, `min_tick`, `hour_tick` and `day_tick` all high for one cycle.
- Load 00:09:59 and apply one rise → 00:10:00 with `min_tick`=1 and `hour_tick`=0. Load 00:00:09 and apply one rise → 00:00:10 with no `min_tick`.
- Load 24:00:00, then 12:5A:00, then 12:60:00 → `load_err` pulses each time and the time is unchanged. Load 12:34:56 → accepted, no `load_err`.
- `run`=0 for 5 `sec_clk` rises → time unchanged and no strobes. `run`=1 → the next rise increments by exactly one second.
- Assert `load`=08:00:00 in the same cycle as a counted `rise` → 08:00:00 with no `sec_tick`. Assert `rst_n`=0 mid-count at 10:20:30 → immediately 00:00:00 with all strobes 0.
